acq_trigger_ctrl: RTL

ACQ_TRIGGER_CTRL -- requirements
Module: acq_trigger_ctrl

---
 rtl/dso_pkg.sv | 29 ++
 rtl/trig_edge_det.sv | 34 +++
 rtl/acq_trigger_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dso_pkg.sv
// Shared types, depth constants and trigger-mode codes for the scope acquisition path.
package dso_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRETRIG  = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POSTTRIG = 3'd3,
    ST_HOLD     = 3'd4
  } acq_state_t;

  localparam logic [8:0] DEPTH_SINGLE = 9'd200;
  localparam logic [8:0] DEPTH_DOUBLE = 9'd400;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_AUTO   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd2;

  function automatic logic [8:0] addr_inc(input logic [8:0] addr, input logic [8:0] depth);
    return (addr == depth - 9'd1) ? 9'd0 : addr + 9'd1;
  endfunction

  // Result is always below depth, so wrapping at 512 still yields the right value.
  function automatic logic [8:0] addr_sub(input logic [8:0] a, input logic [8:0] b,
                                          input logic [8:0] depth);
    return (a >= b) ? a - b : a + depth - b;
  endfunction

endpackage

// File: rtl/trig_edge_det.sv
// Level-crossing detector: remembers the previous accepted sample and flags a crossing.
module trig_edge_det #(
  parameter int SMP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             accept,
  input  logic [SMP_W-1:0] cur,
  input  logic [SMP_W-1:0] level,
  input  logic             rising,
  output logic             hit
);

  logic [SMP_W-1:0] prev;
  logic             prev_valid;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (accept) begin
      prev       <= cur;
      prev_valid <= 1'b1;
    end
  end

  always_comb begin
    hit = 1'b0;
    if (prev_valid)
      hit = rising ? (prev < level && cur >= level) : (prev > level && cur <= level);
  end

endmodule

// File: rtl/acq_trigger_ctrl.sv
// Acquisition sequencer: fills a circular sample RAM around a trigger and freezes the frame.
//   state    | meaning
//   IDLE     | stopped; depth latched on exit
//   PRETRIG  | filling the pre-trigger half
//   ARMED    | writing and looking for a trigger (or auto timeout)
//   POSTTRIG | writing the post-trigger part
//   HOLD     | frame frozen for the display
module acq_trigger_ctrl
  import dso_pkg::*;
#(
  parameter logic [15:0] AUTO_TIMEOUT = 16'd50000,
  parameter int          SMP_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             smp_valid,
  input  logic [SMP_W-1:0] adc_data,
  input  logic             sample_type,
  input  logic [SMP_W-1:0] trig_level,
  input  logic             trig_edge,
  input  logic [1:0]       trig_mode,
  input  logic             run,
  input  logic             disp_done,
  output logic             wr_en,
  output logic [8:0]       wr_addr,
  output logic [8:0]       frame_start,
  output logic             frame_ready,
  output logic             trig_forced,
  output logic [2:0]       state
);

  acq_state_t  st;
  logic [8:0]  depth;
  logic [8:0]  pre;
  logic [8:0]  trig_addr;
  logic [15:0] smp_cnt;
  logic        single_done;
  logic        edge_hit;
  logic        capturing;
  logic        timeout;
  logic        clear_prev;
  logic [8:0]  next_addr;
  logic [8:0]  post_last;

  assign state      = st;
  assign capturing  = (st == ST_PRETRIG) || (st == ST_ARMED) || (st == ST_POSTTRIG);
  assign wr_en      = smp_valid && run && !reset && capturing;
  assign clear_prev = (st == ST_IDLE) || (st == ST_HOLD);
  assign next_addr  = addr_inc(wr_addr, depth);
  assign post_last  = depth - pre - 9'd2;
  assign timeout    = (trig_mode == MODE_AUTO) && (smp_cnt == AUTO_TIMEOUT - 16'd1);

  trig_edge_det #(.SMP_W(SMP_W)) u_edge (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear_prev),
    .accept (wr_en),
    .cur    (adc_data),
    .level  (trig_level),
    .rising (trig_edge),
    .hit    (edge_hit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      st          <= ST_IDLE;
      wr_addr     <= '0;
      frame_start <= '0;
      frame_ready <= 1'b0;
      trig_forced <= 1'b0;
      smp_cnt     <= '0;
      depth       <= DEPTH_SINGLE;
      pre         <= DEPTH_SINGLE >> 1;
      trig_addr   <= '0;
      single_done <= 1'b0;
    end else if (!run) begin
      st          <= ST_IDLE;
      frame_ready <= 1'b0;
      smp_cnt     <= '0;
      single_done <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          // After a single-shot frame, wait for run to be toggled before re-arming.
          if (!single_done) begin
            st      <= ST_PRETRIG;
            depth   <= sample_type ? DEPTH_DOUBLE : DEPTH_SINGLE;
            pre     <= sample_type ? (DEPTH_DOUBLE >> 1) : (DEPTH_SINGLE >> 1);
            wr_addr <= '0;
            smp_cnt <= '0;
          end
        end
        ST_PRETRIG: begin
          if (smp_valid) begin
            wr_addr <= next_addr;
            if (smp_cnt == {7'd0, pre - 9'd1}) begin
              st      <= ST_ARMED;
              smp_cnt <= '0;
            end else begin
              smp_cnt <= smp_cnt + 16'd1;
            end
          end
        end
        ST_ARMED: begin
          if (smp_valid) begin
            wr_addr <= next_addr;
            if (edge_hit || timeout) begin
              st          <= ST_POSTTRIG;
              trig_addr   <= wr_addr;
              trig_forced <= !edge_hit;
              smp_cnt     <= '0;
            end else begin
              smp_cnt <= smp_cnt + 16'd1;
            end
          end
        end
        ST_POSTTRIG: begin
          if (smp_valid) begin
            wr_addr <= next_addr;
            if (smp_cnt == {7'd0, post_last}) begin
              st          <= ST_HOLD;
              frame_ready <= 1'b1;
              frame_start <= addr_sub(trig_addr, pre, depth);
              smp_cnt     <= '0;
            end else begin
              smp_cnt <= smp_cnt + 16'd1;
            end
          end
        end
        ST_HOLD: begin
          if (disp_done) begin
            frame_ready <= 1'b0;
            if (trig_mode == MODE_SINGLE) begin
              st          <= ST_IDLE;
              single_done <= 1'b1;
            end else begin
              st      <= ST_PRETRIG;
              wr_addr <= '0;
              smp_cnt <= '0;
            end
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule
